// File: rtl/prbs8_checker.sv
// -----------------------------------------------------------------------------
// prbs8_checker
//
// Purpose:
//   Checks a stream of 8-bit LFSR state words. Each word is compared with
//   the successor of the previous word. The checker first searches for a seed
//   and then verifies LOCK_COUNT consecutive matches. Once locked, it
//   flywheels its own expected sequence. While locked, it flags and counts
//   every mismatching beat. UNLOCK_ERRS consecutive mismatches send it back
//   to search.
//
// Parameters:
//   LOCK_COUNT  - consecutive matching beats needed to lock (1..255)
//   UNLOCK_ERRS - consecutive mismatching beats that drop lock (1..255)
//   ERR_CNT_W   - width of the saturating error counter (>= 2)
//
// Ports:
//   aclk      in   clock, rising-edge active
//   aresetn   in   asynchronous active-low reset
//   s_valid   in   qualifies s_data (no backpressure)
//   s_data    in   8-bit LFSR state word
//   clr       in   synchronous clear of err_count (wins over an increment)
//   locked    out  high while in the LOCKED state
//   err_pulse out  one-cycle flag after each mismatching beat while locked
//   err_count out  saturating count of mismatches seen while locked
// -----------------------------------------------------------------------------
module prbs8_checker #(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // Compute the LFSR successor: rotate left, then fold the outgoing bit 7
  // into taps 6..4. The all-zero word is a lock-up state of this LFSR, so it
  // is steered to 0xFF.
  function automatic logic [7:0] prbs_next(input logic [7:0] s);
    logic [7:0] n;
    n = {s[6:0], s[7]} ^ {1'b0, {3{s[7]}}, 4'b0000};
    return (s == 8'h00) ? 8'hFF : n;
  endfunction

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

  state_t     state_reg;
  logic [7:0] exp_reg;
  logic [7:0] match_cnt_reg;
  logic [7:0] bad_run_reg;

  logic match;
  logic err_inc;

  assign match   = (s_data == exp_reg);
  assign err_inc = s_valid && (state_reg == LOCKED) && !match;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= SEARCH;
      exp_reg       <= 8'h00;
      match_cnt_reg <= 8'h00;
      bad_run_reg   <= 8'h00;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
    end else begin
      // err_pulse reflects only the beat of the previous cycle.
      err_pulse <= err_inc;

      if (clr) begin
        err_count <= '0;
      end else if (err_inc && !(&err_count)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end

      if (s_valid) begin
        unique case (state_reg)
          SEARCH: begin
            exp_reg       <= prbs_next(s_data);
            match_cnt_reg <= 8'h00;
            state_reg     <= VERIFY;
          end
          VERIFY: begin
            // The incoming word always reseeds the expectation while verifying.
            exp_reg <= prbs_next(s_data);
            if (match) begin
              match_cnt_reg <= match_cnt_reg + 8'h01;
              if (match_cnt_reg == LOCK_LAST) begin
                state_reg   <= LOCKED;
                bad_run_reg <= 8'h00;
                locked      <= 1'b1;
              end
            end else begin
              match_cnt_reg <= 8'h00;
            end
          end
          LOCKED: begin
            // Flywheel: the expectation advances from itself, not from s_data.
            exp_reg <= prbs_next(exp_reg);
            if (match) begin
              bad_run_reg <= 8'h00;
            end else begin
              bad_run_reg <= bad_run_reg + 8'h01;
              if (bad_run_reg == UNLOCK_LAST) begin
                state_reg <= SEARCH;
                locked    <= 1'b0;
              end
            end
          end
          default: begin
            state_reg <= SEARCH;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/prbs8_checker.md
PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 The module SHALL have parameter LOCK_COUNT, default 4, giving the consecutive matching beats needed to lock (legal range 1..255).
REQ-002 The module SHALL have parameter UNLOCK_ERRS, default 4, giving the consecutive mismatching beats that drop lock (legal range 1..255).
REQ-003 The module SHALL have parameter ERR_CNT_W, default 16, giving the error counter width (minimum 2).
REQ-004 aclk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 aresetn  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 s_valid  input  1  SHALL qualify s_data; no backpressure, every valid beat is consumed.
REQ-007 s_data  input  8  SHALL carry one 8-bit LFSR state word per valid beat.
REQ-008 clr  input  1  SHALL synchronously clear err_count.
REQ-009 locked  output  1  SHALL be high while in LOCKED state (registered).
REQ-010 err_pulse  output  1  SHALL be a one-cycle registered flag for each mismatching beat while LOCKED.
REQ-011 err_count  output  ERR_CNT_W  SHALL be the saturating count of mismatches seen while LOCKED.

Function
REQ-012 next(s) SHALL be: n7=s6, n6=s5^s7, n5=s4^s7, n4=s3^s7, n3=s2, n2=s1, n1=s0, n0=s7; next(0x00) SHALL be 0xFF.
REQ-013 States SHALL be SEARCH, VERIFY, LOCKED; with s_valid low, no state, counter or expected-word change occurs.
REQ-014 SEARCH, valid beat: exp <= next(s_data), match_cnt <= 0, go to VERIFY.
REQ-015 VERIFY, valid beat with s_data==exp: exp <= next(s_data), match_cnt++; when this is the LOCK_COUNT-th consecutive match, go to LOCKED, bad_run <= 0.
REQ-016 VERIFY, valid beat with mismatch: exp <= next(s_data) (reseed), match_cnt <= 0, stay in VERIFY; no err_pulse, no err_count change.
REQ-017 LOCKED, valid beat: exp <= next(exp) (flywheel, independent of s_data), whether or not the beat matches.
REQ-018 LOCKED, mismatch: err_pulse high the next cycle, err_count +1 saturating at all-ones, bad_run++; at the UNLOCK_ERRS-th consecutive mismatch go to SEARCH.
REQ-019 LOCKED, match: bad_run <= 0, err_pulse low the next cycle.
REQ-020 locked SHALL rise the cycle after the locking beat and fall the cycle after the unlocking beat; err_pulse is still asserted for the unlocking beat.
REQ-021 clr SHALL have priority over an increment in the same cycle (result 0); clr SHALL not affect state, locked or err_pulse.
REQ-022 err_pulse SHALL be low in every cycle not following a LOCKED mismatch beat, including cycles following idle (s_valid low) cycles.

Reset
REQ-023 While aresetn is low: state=SEARCH, exp=0x00, match_cnt=0, bad_run=0, locked=0, err_pulse=0, err_count=0, immediately, independent of aclk.
REQ-024 Reset asserted mid-operation SHALL discard lock and counts; after release, operation resumes from SEARCH on the next valid beat.

Verification
REQ-025 Reset: assert aresetn low with no clock edge -> all outputs 0 immediately; after release and idle s_valid -> outputs stay 0.
REQ-026 Lock: back-to-back beats 0xFF,0x8F,0x6F,0xDE,0xCD (defaults) -> locked=1 the cycle after 0xCD, err_count=0, err_pulse never high.
REQ-027 Single error: locked, one beat sent as expected^0x01 then correct sequence resumes -> exactly one err_pulse cycle, err_count=1, locked stays 1.
REQ-028 Loss/relock: 4 consecutive corrupted beats -> locked=0 after 4th, err_count=4; then 5 clean sequential beats -> locked=1 again, err_count still 4.
REQ-029 Gaps/zero: random s_valid idle cycles inserted in a locked stream -> no errors; beat 0x00 in SEARCH followed by 0xFF counts as a match.
REQ-030 Saturation/clr: ERR_CNT_W=4, UNLOCK_ERRS=255, 20 mismatches while locked -> err_count=15; clr coincident with a mismatch -> err_count=0, err_pulse still 1.
